// File: rtl/dmem_responder.sv
// Data-memory responder: one outstanding load/store, byte-lane steering,
// load extension, and word-boundary split into two SRAM accesses.
module dmem_responder #(
  parameter int unsigned ADDR_W  = 14,
  parameter int unsigned MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [31:0]       req_addr,
  input  logic [2:0]        req_mask,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  localparam logic [2:0] M_BYTE  = 3'd0;
  localparam logic [2:0] M_HALF  = 3'd1;
  localparam logic [2:0] M_WORD  = 3'd2;
  localparam logic [2:0] M_UBYTE = 3'd3;
  localparam logic [2:0] M_UHALF = 3'd4;
  localparam int unsigned CNT_W  = 2;

  typedef enum logic [2:0] {
    S_IDLE, S_ACC0, S_WAIT0, S_ACC1, S_WAIT1, S_ERR, S_RESP
  } state_t;

  state_t state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;

  logic              r_we;
  logic [1:0]        r_off;
  logic [ADDR_W-1:0] r_wa;
  logic [2:0]        r_mask;
  logic [31:0]       r_wdata;
  logic [31:0]       w0;

  logic              req_ready_n, rsp_valid_n, rsp_err_n;
  logic [31:0]       rsp_rdata_n;
  logic              mem_en_n, mem_we_n;
  logic [3:0]        mem_be_n;
  logic [ADDR_W-1:0] mem_addr_n;
  logic [31:0]       mem_wdata_n;

  logic              accept;
  logic              s_we;
  logic [1:0]        s_off;
  logic [ADDR_W-1:0] s_wa;
  logic [2:0]        s_mask;
  logic [31:0]       s_wdata;
  logic [2:0]        s_size;
  logic              s_split;
  logic              req_bad;
  logic [3:0]        be_base;
  logic [7:0]        be64;
  logic [63:0]       wd64;
  logic [63:0]       words;
  logic [31:0]       sh;
  logic [31:0]       ext;

  assign accept = req_valid && req_ready;

  // Request view used to build SRAM controls: live inputs on accept, else the latched request
  assign s_we    = accept ? req_we    : r_we;
  assign s_off   = accept ? req_addr[1:0] : r_off;
  assign s_wa    = accept ? req_addr[ADDR_W+1:2] : r_wa;
  assign s_mask  = accept ? req_mask  : r_mask;
  assign s_wdata = accept ? req_wdata : r_wdata;

  always_comb begin
    s_size  = 3'd1;
    be_base = 4'b0001;
    case (s_mask)
      M_HALF, M_UHALF: begin s_size = 3'd2; be_base = 4'b0011; end
      M_WORD:          begin s_size = 3'd4; be_base = 4'b1111; end
      default:         begin s_size = 3'd1; be_base = 4'b0001; end
    endcase
  end

  assign s_split = (4'(s_off) + 4'(s_size)) > 4'd4;
  assign req_bad = (req_mask > M_UHALF) ||
                   ((req_addr >> (ADDR_W + 2)) != 32'd0) ||
                   (s_split && (s_wa == {ADDR_W{1'b1}}));

  assign be64 = {4'b0000, be_base} << s_off;
  assign wd64 = {32'd0, s_wdata} << {s_off, 3'b000};

  // Load extraction: second word comes straight from the SRAM when leaving WAIT1
  assign words = (state == S_WAIT1) ? {mem_rdata, w0} : {32'd0, mem_rdata};
  assign sh    = 32'(words >> {r_off, 3'b000});

  always_comb begin
    ext = 32'd0;
    case (r_mask)
      M_BYTE:  ext = {{24{sh[7]}}, sh[7:0]};
      M_HALF:  ext = {{16{sh[15]}}, sh[15:0]};
      M_UBYTE: ext = {24'd0, sh[7:0]};
      M_UHALF: ext = {16'd0, sh[15:0]};
      M_WORD:  ext = sh;
      default: ext = 32'd0;
    endcase
  end

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    req_ready_n = 1'b0;
    rsp_valid_n = 1'b0;
    rsp_err_n   = 1'b0;
    rsp_rdata_n = 32'd0;
    mem_en_n    = 1'b0;
    mem_we_n    = 1'b0;
    mem_be_n    = 4'd0;
    mem_addr_n  = '0;
    mem_wdata_n = 32'd0;

    case (state)
      S_IDLE:  if (accept) state_n = req_bad ? S_ERR : S_ACC0;
      S_ACC0: begin
        if (!r_we) begin
          state_n = S_WAIT0;
          cnt_n   = CNT_W'(MEM_LAT - 1);
        end else begin
          state_n = s_split ? S_ACC1 : S_RESP;
        end
      end
      S_WAIT0: begin
        if (cnt == '0) state_n = s_split ? S_ACC1 : S_RESP;
        else           cnt_n   = cnt - CNT_W'(1);
      end
      S_ACC1: begin
        if (!r_we) begin
          state_n = S_WAIT1;
          cnt_n   = CNT_W'(MEM_LAT - 1);
        end else begin
          state_n = S_RESP;
        end
      end
      S_WAIT1: begin
        if (cnt == '0) state_n = S_RESP;
        else           cnt_n   = cnt - CNT_W'(1);
      end
      S_ERR:   state_n = S_RESP;
      S_RESP:  if (rsp_ready) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase

    // Registered outputs are computed for the state being entered
    if (state_n == S_ACC0 || state_n == S_ACC1) begin
      mem_en_n   = 1'b1;
      mem_we_n   = s_we;
      mem_addr_n = (state_n == S_ACC1) ? s_wa + ADDR_W'(1) : s_wa;
      if (s_we) begin
        mem_be_n    = (state_n == S_ACC1) ? be64[7:4]   : be64[3:0];
        mem_wdata_n = (state_n == S_ACC1) ? wd64[63:32] : wd64[31:0];
      end else begin
        mem_be_n    = 4'hF;
      end
    end

    req_ready_n = (state_n == S_IDLE);
    rsp_valid_n = (state_n == S_RESP);
    if (state_n == S_RESP) begin
      if (state == S_RESP) begin
        rsp_err_n   = rsp_err;
        rsp_rdata_n = rsp_rdata;
      end else begin
        rsp_err_n   = (state == S_ERR);
        rsp_rdata_n = (state == S_WAIT0 || state == S_WAIT1) ? ext : 32'd0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= 32'd0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_be    <= 4'd0;
      mem_addr  <= '0;
      mem_wdata <= 32'd0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      req_ready <= req_ready_n;
      rsp_valid <= rsp_valid_n;
      rsp_err   <= rsp_err_n;
      rsp_rdata <= rsp_rdata_n;
      mem_en    <= mem_en_n;
      mem_we    <= mem_we_n;
      mem_be    <= mem_be_n;
      mem_addr  <= mem_addr_n;
      mem_wdata <= mem_wdata_n;
    end
  end

  // Request latch and first-word capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_we    <= 1'b0;
      r_off   <= 2'd0;
      r_wa    <= '0;
      r_mask  <= 3'd0;
      r_wdata <= 32'd0;
      w0      <= 32'd0;
    end else begin
      if (accept) begin
        r_we    <= req_we;
        r_off   <= req_addr[1:0];
        r_wa    <= req_addr[ADDR_W+1:2];
        r_mask  <= req_mask;
        r_wdata <= req_wdata;
      end
      if (state == S_WAIT0 && cnt == '0) w0 <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed vector table, reset corner case and
// random traffic checked against a byte-addressed memory model.
module tb_dmem_responder;

  localparam int unsigned AW = 14;
  localparam int unsigned ML = 3;
  localparam int unsigned NW = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid, req_ready, req_we;
  logic [31:0]   req_addr, req_wdata;
  logic [2:0]    req_mask;
  logic          rsp_valid, rsp_ready, rsp_err;
  logic [31:0]   rsp_rdata;
  logic          mem_en, mem_we;
  logic [3:0]    mem_be;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  dmem_responder #(.ADDR_W(AW), .MEM_LAT(ML)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_mask(req_mask), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: bound expired", name);
  endtask

  function automatic logic [31:0] hash(input int i);
    return (32'(i) * 32'h9E3779B1) ^ 32'h5A5A1234;
  endfunction

  // SRAM model with MEM_LAT-deep read pipeline; garbage when not reading
  logic [31:0] sram [NW];
  logic [31:0] pipe [ML];
  logic        loaded = 1'b0;
  always @(posedge clk) begin
    if (!loaded) begin
      for (int i = 0; i < int'(NW); i++) sram[i] <= hash(i);
      loaded <= 1'b1;
    end else if (mem_en && mem_we) begin
      for (int b = 0; b < 4; b++)
        if (mem_be[b]) sram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
    pipe[0] <= (mem_en && !mem_we) ? sram[mem_addr] : $urandom;
    for (int i = 1; i < int'(ML); i++) pipe[i] <= pipe[i-1];
  end
  assign mem_rdata = pipe[ML-1];

  typedef struct {
    int            cyc;
    logic          we;
    logic [AW-1:0] addr;
    logic [3:0]    be;
    logic [31:0]   wd;
  } acc_t;

  acc_t alog[$];
  int   gcyc = 0;
  logic mon_on = 1'b0;
  logic idle_dirty = 1'b0;

  always @(posedge clk) begin
    if (mem_en) alog.push_back(acc_t'{gcyc, mem_we, mem_addr, mem_be, mem_wdata});
    else if (mon_on && (mem_we || mem_be != 4'd0 || mem_addr != '0 || mem_wdata != 32'd0))
      idle_dirty = 1'b1;
    gcyc = gcyc + 1;
  end

  // Reference memory: plain byte array, little-endian
  logic [7:0] ref_b [4*NW];

  function automatic logic [31:0] wref(input int w);
    return {ref_b[4*w+3], ref_b[4*w+2], ref_b[4*w+1], ref_b[4*w]};
  endfunction

  function automatic int size_of(input logic [2:0] m);
    if (m == 3'd2) return 4;
    if (m == 3'd1 || m == 3'd4) return 2;
    return 1;
  endfunction

  function automatic void model(input logic we, input logic [31:0] addr, input logic [2:0] m,
                                input logic [31:0] wd, output logic [31:0] rd, output logic err);
    int sz;
    logic [31:0] v;
    sz  = size_of(m);
    rd  = 32'd0;
    err = (m > 3'd4) || (addr >= 32'(4*NW)) ||
          ((int'(addr % 4) + sz > 4) && (addr / 4 == 32'(NW - 1)));
    if (err) return;
    if (we) begin
      for (int j = 0; j < sz; j++) ref_b[int'(addr) + j] = wd[8*j +: 8];
    end else begin
      v = 32'd0;
      for (int j = 0; j < sz; j++) v = v | (32'(ref_b[int'(addr) + j]) << (8*j));
      if (m == 3'd0 && v[7])  v = v | 32'hFFFF_FF00;
      if (m == 3'd1 && v[15]) v = v | 32'hFFFF_0000;
      rd = v;
    end
  endfunction

  function automatic logic any_out();
    return req_ready | rsp_valid | rsp_err | (|rsp_rdata) | mem_en | mem_we |
           (|mem_be) | (|mem_addr) | (|mem_wdata);
  endfunction

  task automatic run(input logic we, input logic [31:0] addr, input logic [2:0] m,
                     input logic [31:0] wd, input int hold, input logic use_model,
                     input logic [31:0] hrd, input logic herr);
    logic [31:0]   mrd, exp_rd, held, lm, ewd;
    logic          merr, exp_err, split, stable;
    logic [AW-1:0] wa;
    logic [3:0]    eb;
    int            sz, off, nacc, lat, elat, t, c0, p;
    acc_t          a;
    model(we, addr, m, wd, mrd, merr);
    exp_rd  = use_model ? mrd  : hrd;
    exp_err = use_model ? merr : herr;
    sz    = size_of(m);
    off   = int'(addr[1:0]);
    wa    = addr[AW+1:2];
    split = (off + sz) > 4;

    t = 0;
    while (!req_ready && t < 20) begin @(negedge clk); t++; end
    if (!req_ready) begin fail("req_ready_wait"); return; end
    alog.delete();
    c0 = gcyc;
    req_valid = 1'b1; req_we = we; req_addr = addr; req_mask = m; req_wdata = wd;
    @(posedge clk); #1;
    lat = 0;
    do begin
      req_valid = 1'($urandom_range(0, 1));
      req_we    = 1'($urandom_range(0, 1));
      req_addr  = $urandom;
      req_mask  = 3'($urandom_range(0, 7));
      req_wdata = $urandom;
      @(negedge clk);
      lat++;
    end while (!rsp_valid && lat < 60);
    req_valid = 1'b0;
    if (!rsp_valid) begin fail("rsp_timeout"); return; end

    elat = merr ? 2 : we ? (split ? 3 : 2) : (split ? 3 + 2*int'(ML) : 2 + int'(ML));
    chk("latency", 32'(lat), 32'(elat));
    chk("rdata", rsp_rdata, exp_rd);
    chk("err", 32'(rsp_err), 32'(exp_err));
    chk("req_ready_busy", 32'(req_ready), 32'd0);

    held = rsp_rdata;
    stable = 1'b1;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      if (!rsp_valid || rsp_rdata !== held || rsp_err !== exp_err || req_ready) stable = 1'b0;
    end
    chk("hold_stable", 32'(stable), 32'd1);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("rsp_drop", 32'(rsp_valid), 32'd0);
    chk("ready_after_rsp", 32'(req_ready), 32'd1);

    nacc = merr ? 0 : (split ? 2 : 1);
    chk("acc_count", 32'(alog.size()), 32'(nacc));
    if (alog.size() == nacc) begin
      for (int k = 0; k < nacc; k++) begin
        a   = alog[k];
        eb  = 4'd0;
        ewd = 32'd0;
        lm  = 32'd0;
        for (int j = 0; j < sz; j++) begin
          p = off + j;
          if (p / 4 == k) begin
            eb[p % 4] = 1'b1;
            ewd[8*(p % 4) +: 8] = wd[8*j +: 8];
            lm[8*(p % 4) +: 8]  = 8'hFF;
          end
        end
        chk("acc_cycle", 32'(a.cyc - c0), 32'((k == 0) ? 1 : (we ? 2 : 2 + int'(ML))));
        chk("acc_addr", 32'(a.addr), 32'(wa) + 32'(k));
        chk("acc_we", 32'(a.we), 32'(we));
        chk("acc_be", 32'(a.be), we ? 32'(eb) : 32'hF);
        if (we) chk("acc_wdata", a.wd & lm, ewd);
      end
    end

    if (we) begin
      chk("sram_word0", sram[wa], wref(int'(wa)));
      if (32'(wa) + 1 < NW) chk("sram_word1", sram[wa + AW'(1)], wref(int'(wa) + 1));
    end
  endtask

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [2:0]  mask;
    logic [31:0] wd;
    int          hold;
    logic [31:0] rd;
    logic        err;
  } vec_t;

  vec_t tbl[$];
  int   rsel;
  logic [31:0] raddr;
  logic [2:0]  rmask;
  logic seen;
  int   t0;

  initial begin
    req_valid = 1'b0; req_we = 1'b0; req_addr = 32'd0; req_mask = 3'd0; req_wdata = 32'd0;
    rsp_ready = 1'b0;
    for (int i = 0; i < int'(NW); i++)
      for (int b = 0; b < 4; b++) ref_b[4*i + b] = hash(i)[8*b +: 8];

    repeat (3) @(negedge clk);
    chk("reset_outputs", 32'(any_out()), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", 32'(req_ready), 32'd1);
    mon_on = 1'b1;

    // we, addr, mask, wdata, hold, rdata, err
    tbl.push_back(vec_t'{1'b1, 32'h0000_0100, 3'd2, 32'hDEAD_BEEF, 0, 32'h0000_0000, 1'b0});
    tbl.push_back(vec_t'{1'b0, 32'h0000_0100, 3'd2, 32'h0,         0, 32'hDEAD_BEEF, 1'b0});
    tbl.push_back(vec_t'{1'b1, 32'h0000_0203, 3'd0, 32'h1234_5680, 1, 32'h0000_0000, 1'b0});
    tbl.push_back(vec_t'{1'b0, 32'h0000_0203, 3'd0, 32'h0,         0, 32'hFFFF_FF80, 1'b0});
    tbl.push_back(vec_t'{1'b0, 32'h0000_0203, 3'd3, 32'h0,         0, 32'h0000_0080, 1'b0});
    tbl.push_back(vec_t'{1'b1, 32'h0000_0200, 3'd2, 32'h1122_3344, 0, 32'h0000_0000, 1'b0});
    tbl.push_back(vec_t'{1'b1, 32'h0000_0204, 3'd2, 32'h5566_7788, 0, 32'h0000_0000, 1'b0});
    tbl.push_back(vec_t'{1'b0, 32'h0000_0203, 3'd1, 32'h0,         0, 32'hFFFF_8811, 1'b0});
    tbl.push_back(vec_t'{1'b0, 32'h0000_0203, 3'd4, 32'h0,         2, 32'h0000_8811, 1'b0});
    tbl.push_back(vec_t'{1'b1, 32'h0000_0203, 3'd1, 32'h0000_AABB, 0, 32'h0000_0000, 1'b0});
    tbl.push_back(vec_t'{1'b0, 32'h0000_0200, 3'd2, 32'h0,         0, 32'hBB22_3344, 1'b0});
    tbl.push_back(vec_t'{1'b0, 32'h0000_0204, 3'd2, 32'h0,         0, 32'h5566_77AA, 1'b0});
    tbl.push_back(vec_t'{1'b0, 32'h0000_0203, 3'd4, 32'h0,         0, 32'h0000_AABB, 1'b0});
    tbl.push_back(vec_t'{1'b0, 32'h0000_0100, 3'd6, 32'h0,         1, 32'h0000_0000, 1'b1});
    tbl.push_back(vec_t'{1'b0, 32'hFFFF_0000, 3'd2, 32'h0,         0, 32'h0000_0000, 1'b1});
    tbl.push_back(vec_t'{1'b1, 32'h0000_0100, 3'd7, 32'h1111_1111, 0, 32'h0000_0000, 1'b1});
    tbl.push_back(vec_t'{1'b0, 32'h0000_0100, 3'd2, 32'h0,         0, 32'hDEAD_BEEF, 1'b0});
    tbl.push_back(vec_t'{1'b1, 32'h0000_FFFC, 3'd2, 32'hA1B2_C3D4, 0, 32'h0000_0000, 1'b0});
    tbl.push_back(vec_t'{1'b1, 32'h0000_FFFF, 3'd0, 32'h0000_007F, 0, 32'h0000_0000, 1'b0});
    tbl.push_back(vec_t'{1'b0, 32'h0000_FFFF, 3'd0, 32'h0,         0, 32'h0000_007F, 1'b0});
    tbl.push_back(vec_t'{1'b0, 32'h0000_FFFE, 3'd1, 32'h0,         0, 32'h0000_7FB2, 1'b0});
    tbl.push_back(vec_t'{1'b0, 32'h0000_FFFC, 3'd2, 32'h0,         0, 32'h7FB2_C3D4, 1'b0});
    tbl.push_back(vec_t'{1'b0, 32'h0000_FFFF, 3'd1, 32'h0,         0, 32'h0000_0000, 1'b1});
    tbl.push_back(vec_t'{1'b1, 32'h0000_FFFE, 3'd2, 32'h0BAD_0BAD, 0, 32'h0000_0000, 1'b1});
    tbl.push_back(vec_t'{1'b1, 32'h0000_0104, 3'd2, 32'hCAFE_F00D, 0, 32'h0000_0000, 1'b0});
    tbl.push_back(vec_t'{1'b0, 32'h0000_0102, 3'd2, 32'h0,         5, 32'hF00D_DEAD, 1'b0});

    for (int i = 0; i < tbl.size(); i++)
      run(tbl[i].we, tbl[i].addr, tbl[i].mask, tbl[i].wd, tbl[i].hold, 1'b0, tbl[i].rd, tbl[i].err);

    // Reset pulsed while a load sits in WAIT0
    t0 = 0;
    while (!req_ready && t0 < 20) begin @(negedge clk); t0++; end
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h100; req_mask = 3'd2;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk("reset_async_outputs", 32'(any_out()), 32'd0);
    @(negedge clk);
    chk("reset_held_outputs", 32'(any_out()), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_first_cycle", 32'(req_ready), 32'd1);
    seen = 1'b0;
    repeat (10) begin @(negedge clk); if (rsp_valid) seen = 1'b1; end
    chk("no_rsp_after_reset", 32'(seen), 32'd0);

    for (int n = 0; n < 200; n++) begin
      rsel = $urandom_range(0, 7);
      if (rsel < 6)       raddr = 32'h400 + 32'($urandom_range(0, 63));
      else if (rsel == 6) raddr = 32'(4*NW - 8) + 32'($urandom_range(0, 7));
      else                raddr = $urandom;
      rmask = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 4)) : 3'($urandom_range(5, 7));
      run(1'($urandom_range(0, 1)), raddr, rmask, $urandom, $urandom_range(0, 2), 1'b1, 32'd0, 1'b0);
    end

    chk("sram_idle_zero", 32'(idle_dirty), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Memory-side responder for the CPU data port. It accepts one load/store request at a time, tagged with a `mem_mask_t` size code, and drives a word-wide synchronous SRAM. It generates byte enables and shifted write data, and extracts and sign- or zero-extends load data. Misaligned accesses that cross a word boundary are split into two SRAM accesses. It sits between the CPU memory stage and the data SRAM.

## Interface
- `ADDR_W`, default 14: SRAM word-address width; memory size is 4·2^ADDR_W bytes.
- `MEM_LAT`, default 1: SRAM read latency in cycles, legal range 1..3.

- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  responder idle; request accepted when `req_valid && req_ready`.
- `req_we`  in  1  1 = store, 0 = load.
- `req_addr`  in  32  byte address.
- `req_mask`  in  3  `mem_mask_t`: BYTE=0, HALF=1, WORD=2, UBYTE=3, UHALF=4.
- `req_wdata`  in  32  store data, right-justified.
- `rsp_valid`  out  1  response present; held until `rsp_ready`.
- `rsp_ready`  in  1  CPU accepts response.
- `rsp_rdata`  out  32  extended load data; 0 for stores and errors.
- `rsp_err`  out  1  request rejected; no SRAM access made.
- `mem_en`  out  1  SRAM access strobe.
- `mem_we`  out  1  SRAM write.
- `mem_be`  out  4  byte enables; bit i covers bits 8i+7:8i.
- `mem_addr`  out  ADDR_W  SRAM word address.
- `mem_wdata`  out  32  SRAM write data.
- `mem_rdata`  in  32  SRAM read data, valid MEM_LAT cycles after the `mem_en` read cycle.

## Operation
- Request fields are registered on acceptance.
- Derived values:
  - off = addr[1:0]
  - size = 1 / 2 / 4 bytes (UBYTE and UHALF count as 1 and 2)
  - wa = addr[ADDR_W+1:2]
  - split = off+size > 4
- Error conditions, each giving `rsp_err=1` with no `mem_en`:
  - `req_mask` is 5..7;
  - `addr[31:ADDR_W+2]` is nonzero;
  - split is true and wa is the last word.
- States:
  - IDLE → ERR | ACC0 on accept.
  - ACC0 → WAIT0 (load) | ACC1 (split store) | RESP.
  - WAIT0 → ACC1 (split) | RESP.
  - ACC1 → WAIT1 (load) | RESP.
  - WAIT1 → RESP.
  - ERR → RESP.
  - RESP → IDLE when `rsp_ready`.
- Store byte enables and data:
  - be64 = ((1<<size)−1) << off; wd64 = {32'b0, wdata} << 8·off.
  - ACC0 drives `mem_be`=be64[3:0] and `mem_wdata`=wd64[31:0] at wa.
  - ACC1 drives be64[7:4] and wd64[63:32] at wa+1.
  - Unused bytes of `mem_wdata` are don't-care, but bytes with be=0 must never be written.
- Load path:
  - `mem_be`=4'hF on reads.
  - Word0 is captured at end of WAIT0, word1 at end of WAIT1 (0 if not split).
  - r = ({w1, w0} >> 8·off) truncated to size bytes.
  - BYTE and HALF sign-extend; UBYTE, UHALF and WORD zero-extend.
- SRAM outputs (`mem_en`, `mem_we`, `mem_be`, `mem_addr`, `mem_wdata`) are asserted only in ACC0/ACC1 and are 0 otherwise.
- `rsp_rdata` and `rsp_err` are stable while `rsp_valid` is high.
- Only one request is outstanding at a time. `req_ready` is high only in IDLE.

## Timing
- Reset (`rst_n`=0, asynchronous):
  - state goes to IDLE;
  - all outputs go to 0, including `req_ready`;
  - `req_ready` rises in the first cycle after reset deassertion.
- Cycle 0 is the accept cycle.
  - Aligned store: write in cycle 1, `rsp_valid` in cycle 2.
  - Split store: writes in cycles 1 and 2, `rsp_valid` in cycle 3.
  - Aligned load: read in cycle 1, `rsp_valid` in cycle 2+MEM_LAT.
  - Split load: reads in cycles 1 and 2+MEM_LAT, `rsp_valid` in cycle 3+2·MEM_LAT.
  - Error: `rsp_valid` in cycle 2, no SRAM activity.
- Responses:
  - `rsp_valid` with `rsp_ready` high → IDLE next cycle; the next request can be accepted one cycle after the response handshake.
  - `rsp_ready` low → response held indefinitely; `req_ready` stays 0.
- `req_valid` asserted while `req_ready`=0 is ignored and not latched.
- Reset mid-split-store after ACC0: ACC1 is not issued, so a partial write is permitted; no response is produced.

## Test plan
- Aligned word, MEM_LAT=1:
  - stimulus: store 0xDEADBEEF @0x100, then load WORD @0x100;
  - required: `mem_be`=F at `mem_addr`=0x40, store `rsp_valid` in cycle 2, load `rsp_rdata`=0xDEADBEEF in cycle 3.
- Byte lanes:
  - stimulus: store BYTE 0x80 @0x203, then load BYTE @0x203, then UBYTE @0x203;
  - required: `mem_be`=4'b1000 with data byte 3 = 0x80; rdata = 0xFFFFFF80, then 0x00000080.
- Split halfword:
  - stimulus: word 0x80 = 0x11223344, word 0x81 = 0x55667788; load HALF @0x203;
  - required: two reads (0x80, 0x81), rdata = 0xFFFF8811; a split store of HALF 0xAABB @0x203 gives be 1000 then 0001.
- Errors:
  - stimulus: `req_mask`=6; and WORD @0xFFFF_0000 with ADDR_W=14;
  - required: `rsp_err`=1 in cycle 2, `mem_en` never high, `rsp_rdata`=0.
- Backpressure and MEM_LAT=3:
  - stimulus: split WORD load @0x102 with `rsp_ready` held low for 5 cycles;
  - required: `rsp_valid` from cycle 9 until the handshake, data stable throughout, `req_ready`=0 throughout.
- Reset mid-operation:
  - stimulus: `rst_n` pulsed low in WAIT0 of a load;
  - required: all outputs 0 immediately, no `rsp_valid`, `req_ready`=1 in the first cycle after release.
